branch_predictor_btb: RTL and testbench
=======================================

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, meaning the number of BTB entries; power of 2, from 4 to 256.
REQ-002 SHALL have parameter CTR_W, default 2, meaning the saturating-counter width in bits, from 1 to 3.
REQ-003 SHALL have parameter STAT_W, default 16, meaning the mispredict-counter width.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port lookup_pc, input, 32 bits (word_t): fetch-stage PC.
REQ-007 SHALL have port hit, output, 1 bit: lookup entry is valid and its tag matches.
REQ-008 SHALL have port predict, output, 1 bit: predict taken.
REQ-009 SHALL have port pred_target, output, 32 bits (word_t): next-PC prediction.
REQ-010 SHALL have port pc_en, input, 1 bit: pipeline advance; qualifies updates.
REQ-011 SHALL have port upd_en, input, 1 bit: a resolved branch is presented.
REQ-012 SHALL have port upd_pc, input, 32 bits: PC of the resolved branch.
REQ-013 SHALL have port upd_taken, input, 1 bit: resolved direction.
REQ-014 SHALL have port upd_target, input, 32 bits: resolved taken target.
REQ-015 SHALL have port upd_pred, input, 1 bit: the predict value carried down the pipe with the branch.
REQ-016 SHALL have port flush, input, 1 bit: synchronous invalidate-all.
REQ-017 SHALL have port stat_mispred, output, STAT_W bits: mispredict count.

Function
REQ-018 SHALL use IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
REQ-019 SHALL store per entry: valid, tag, target (32 bits) and counter (CTR_W bits).
REQ-020 SHALL make lookup combinational with zero latency: hit = valid && tag match; predict = hit && counter MSB.
REQ-021 SHALL set pred_target = stored target when predict=1, else lookup_pc+4, wrapping modulo 2^32.
REQ-022 SHALL commit an update only on an edge where upd_en && pc_en; when pc_en=0, state SHALL hold, so a stalled branch updates exactly once.
REQ-023 On an update that hits, the counter SHALL increment on taken (saturating at 2^CTR_W-1) and decrement on not-taken (saturating at 0); on taken, the target SHALL be overwritten.
REQ-024 On an update that misses with upd_taken=1, the entry SHALL be allocated or replaced with valid=1, the new tag, upd_target and counter = 2^(CTR_W-1) (weakly taken).
REQ-025 On an update that misses with upd_taken=0, there SHALL be no allocation and no change.
REQ-026 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return pre-update state (no bypass).
REQ-027 A committed update with upd_pred != upd_taken SHALL increment stat_mispred, saturating at all-ones.
REQ-028 flush SHALL clear all valid bits next edge and leave counters, targets and stat_mispred unchanged.
REQ-029 flush and an update in the same cycle: flush SHALL win and the update SHALL be dropped, while the stat increment still occurs.

Reset
REQ-030 While RST=1, SHALL hold all valid=0, counters = 2^(CTR_W-1)-1 (weakly not-taken), targets=0, tags=0 and stat_mispred=0, independent of CLK.
REQ-031 Outputs during and after reset SHALL be hit=0, predict=0, pred_target=lookup_pc+4.
REQ-032 Reset asserted mid-stall or mid-update SHALL discard the pending update.

Structure
REQ-033 SHALL take word_t from cpu_types_pkg; cpu_types_pkg SHALL add the BP_ENTRIES_DEF and BP_CTR_W_DEF constants.
REQ-034 SHALL instantiate one sub-module, sat_counter (parametrised width, inc/dec/load, saturating), per entry.
REQ-035 SHALL hold storage in flops (no SRAM macro).

Verification (ENTRIES=8, CTR_W=2)
REQ-036 Reset -> lookup 0x00000040 gives hit=0, predict=0, pred_target=0x00000044, stat_mispred=0.
REQ-037 Update 0x100, taken, target 0x200, upd_pred=0, pc_en=1 -> next cycle lookup 0x100 gives hit=1, predict=1, pred_target=0x200, stat=1.
REQ-038 Two more taken updates of 0x100, then two not-taken (upd_pred=1) -> counter 3 then 1; predict=0, hit=1, pred_target=0x104, stat=3.
REQ-039 Taken update 0x120 (index 0, different tag) with target 0x300 -> lookup 0x100 hit=0; lookup 0x120 pred_target=0x300.
REQ-040 upd_en=1, pc_en=0 for 3 cycles, then pc_en=1 for 1 cycle -> exactly one counter step.
REQ-041 flush with a taken update in the same cycle -> all hit=0 next cycle; stat increments if mispredicted; async RST mid-cycle clears stat immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type and branch predictor defaults
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  localparam int BP_ENTRIES_DEF = 8;
  localparam int BP_CTR_W_DEF = 2;
endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// sat_counter: saturating up/down counter with parallel load and async reset
module sat_counter #(
  parameter int W = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= RST_VAL;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with per-entry saturating direction counters
module branch_predictor_btb import cpu_types_pkg::*; #(
  parameter int ENTRIES = BP_ENTRIES_DEF,
  parameter int CTR_W   = BP_CTR_W_DEF,
  parameter int STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  word_t             lookup_pc,
  output logic              hit,
  output logic              predict,
  output word_t             pred_target,
  input  logic              pc_en,
  input  logic              upd_en,
  input  word_t             upd_pc,
  input  logic              upd_taken,
  input  word_t             upd_target,
  input  logic              upd_pred,
  input  logic              flush,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  word_t             r_target [ENTRIES];
  logic [CTR_W-1:0]  w_cnt    [ENTRIES];
  logic [STAT_W-1:0] r_stat;
  logic [IDX_W-1:0]  w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]  w_lk_tag, w_up_tag;
  logic              w_up_hit, w_commit, w_write, w_alloc, w_unused;
  assign w_lk_idx    = lookup_pc[IDX_W+1:2];
  assign w_lk_tag    = lookup_pc[31:IDX_W+2];
  assign w_up_idx    = upd_pc[IDX_W+1:2];
  assign w_up_tag    = upd_pc[31:IDX_W+2];
  assign w_unused    = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};
  assign hit         = r_valid[w_lk_idx] && r_tag[w_lk_idx] == w_lk_tag;
  assign predict     = hit && w_cnt[w_lk_idx][CTR_W-1];
  assign pred_target = predict ? r_target[w_lk_idx] : lookup_pc + 32'd4;
  assign w_up_hit    = r_valid[w_up_idx] && r_tag[w_up_idx] == w_up_tag;
  assign w_commit    = upd_en && pc_en;
  // flush drops the table write but the mispredict is still counted
  assign w_write     = w_commit && !flush;
  assign w_alloc     = w_write && !w_up_hit && upd_taken;
  assign stat_mispred = r_stat;
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    logic w_sel;
    assign w_sel = w_up_idx == IDX_W'(i);
    sat_counter #(.W(CTR_W), .RST_VAL(CTR_WNT)) u_ctr (
      .clk(CLK),
      .rst(RST),
      .i_inc(w_write && w_sel && w_up_hit && upd_taken),
      .i_dec(w_write && w_sel && w_up_hit && !upd_taken),
      .i_load(w_alloc && w_sel),
      .i_load_val(CTR_WT),
      .o_cnt(w_cnt[i])
    );
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int k = 0; k < ENTRIES; k++) begin
        r_valid[k]  <= 1'b0;
        r_tag[k]    <= '0;
        r_target[k] <= '0;
      end
      r_stat <= '0;
    end else begin
      if (w_commit && upd_pred != upd_taken && r_stat != '1) r_stat <= r_stat + 1'b1;
      if (flush) for (int k = 0; k < ENTRIES; k++) r_valid[k] <= 1'b0;
      else if (w_write && upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= upd_target;
      end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: scoreboard bench for the BTB (ENTRIES=8, CTR_W=2)
module tb_branch_predictor_btb;
  import cpu_types_pkg::*;
  typedef struct {string nm; logic [49:0] v;} exp_t;
  logic        CLK = 1'b0, RST = 1'b1;
  word_t       lookup_pc = 32'h40, upd_pc = '0, upd_target = '0, pred_target;
  logic        hit, predict, pc_en = 1'b1, upd_en = 1'b0, upd_taken = 1'b0, upd_pred = 1'b0, flush = 1'b0;
  logic [15:0] stat_mispred;
  exp_t        sb[$];
  exp_t        e;
  logic [49:0] got;
  int          n_chk = 0, n_pass = 0;

  always #5 CLK = ~CLK;

  branch_predictor_btb #(.ENTRIES(8), .CTR_W(2), .STAT_W(16)) dut (
    .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc), .hit(hit), .predict(predict),
    .pred_target(pred_target), .pc_en(pc_en), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred(upd_pred),
    .flush(flush), .stat_mispred(stat_mispred)
  );

  task automatic push(string nm, logic h, logic p, word_t t, logic [15:0] s);
    exp_t x;
    x.nm = nm;
    x.v = {h, p, t, s};
    sb.push_back(x);
  endtask

  task automatic upd(word_t pc, logic tk, word_t tg, logic pr);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_pred = pr;
    @(posedge CLK); #1;
    upd_en = 1'b0;
  endtask

  task automatic test_reset();
    word_t pcs[2] = '{32'h40, 32'hFFFF_FFFC};
    push("reset_held", 0, 0, 32'h44, 0);
    push("after_reset", 0, 0, 32'h44, 0);
    push("wrap_pc", 0, 0, 32'h0, 0);
    #2;
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1 RST = 1'b0;
    for (int j = 0; j < 2; j++) begin
      lookup_pc = pcs[j];
      @(negedge CLK);
      e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
      if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_alloc_and_counter();
    upd(32'h100, 1, 32'h200, 0);
    push("alloc", 1, 1, 32'h200, 1);
    lookup_pc = 32'h100;
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1;
    upd(32'h100, 1, 32'h200, 1);
    upd(32'h100, 1, 32'h200, 1);
    push("ctr_sat3", 1, 1, 32'h200, 1);
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1;
    upd(32'h100, 0, 32'h0, 1);
    upd(32'h100, 0, 32'h0, 1);
    push("ctr_down1", 1, 0, 32'h104, 3);
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_alias_and_nt_miss();
    word_t pcs[3] = '{32'h100, 32'h120, 32'h144};
    upd(32'h120, 1, 32'h300, 0);
    upd(32'h144, 0, 32'h900, 0);
    push("alias_old", 0, 0, 32'h104, 4);
    push("alias_new", 1, 1, 32'h300, 4);
    push("nt_miss_noalloc", 0, 0, 32'h148, 4);
    for (int j = 0; j < 3; j++) begin
      lookup_pc = pcs[j];
      @(negedge CLK);
      e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
      if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_stall();
    upd_en = 1'b1; upd_pc = 32'h120; upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b1;
    pc_en = 1'b0;
    lookup_pc = 32'h120;
    for (int j = 0; j < 3; j++) begin
      push("stall_hold", 1, 1, 32'h300, 4);
      @(negedge CLK);
      e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
      if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
      @(posedge CLK); #1;
    end
    pc_en = 1'b1;
    @(posedge CLK); #1;
    upd_en = 1'b0;
    push("stall_one_step", 1, 0, 32'h124, 5);
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1;
    upd(32'h120, 1, 32'h340, 0);
    push("stall_ctr_back2", 1, 1, 32'h340, 6);
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_no_bypass();
    upd_en = 1'b1; upd_pc = 32'h120; upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b1;
    lookup_pc = 32'h120;
    push("same_cycle_pre", 1, 1, 32'h340, 6);
    push("same_cycle_post", 1, 0, 32'h124, 7);
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1;
    upd_en = 1'b0;
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    word_t pcs[2] = '{32'h204, 32'h208};
    upd_en = 1'b1; upd_pc = 32'h204; upd_taken = 1'b1; upd_target = 32'h500; upd_pred = 1'b0;
    @(posedge CLK); #1;
    upd_pc = 32'h208; upd_target = 32'h600; upd_pred = 1'b1;
    @(posedge CLK); #1;
    upd_en = 1'b0;
    push("b2b_first", 1, 1, 32'h500, 8);
    push("b2b_second", 1, 1, 32'h600, 8);
    for (int j = 0; j < 2; j++) begin
      lookup_pc = pcs[j];
      @(negedge CLK);
      e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
      if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_flush();
    word_t pcs[3] = '{32'h120, 32'h204, 32'h30C};
    flush = 1'b1;
    upd(32'h30C, 1, 32'h800, 0);
    flush = 1'b0;
    push("flush_idx0", 0, 0, 32'h124, 9);
    push("flush_idx1", 0, 0, 32'h208, 9);
    push("flush_drops_upd", 0, 0, 32'h310, 9);
    for (int j = 0; j < 3; j++) begin
      lookup_pc = pcs[j];
      @(negedge CLK);
      e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
      if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_async_reset();
    upd(32'h120, 1, 32'h700, 0);
    upd_en = 1'b1; upd_pc = 32'h120; upd_taken = 1'b0; upd_pred = 1'b1; pc_en = 1'b0;
    lookup_pc = 32'h120;
    push("async_rst_now", 0, 0, 32'h124, 0);
    push("after_async_rst", 0, 0, 32'h124, 0);
    #2 RST = 1'b1;
    #1;
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
    upd_en = 1'b0; pc_en = 1'b1;
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    e = sb.pop_front(); n_chk++; got = {hit, predict, pred_target, stat_mispred};
    if (got !== e.v) $display("FAIL %s: got %h expected %h", e.nm, got, e.v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alloc_and_counter();
    test_alias_and_nt_miss();
    test_stall();
    test_no_bypass();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
